switch_arbiter: RTL and testbench

//  Central scheduler for the 4-port switch. Collects arbitration requests from the four

---
 rtl/switch_arbiter.sv | 155 +++++++++++++++
 tb/tb_switch_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/switch_arbiter.sv
// Central round-robin scheduler for the 4-port switch. It grants a whole multicast target set or nothing, and drives the per-output mux selects.
// Optional build macro ARB_TIMEOUT_EN adds sticky per-input wait-timeout flags.
module switch_arbiter #(
  parameter int NPORTS = 4
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int WAIT_LIMIT = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NPORTS-1:0]     req,
  input  logic [NPORTS*4-1:0]   req_target,
  input  logic [NPORTS-1:0]     out_enable,
  output logic [NPORTS-1:0]     grant,
  output logic [NPORTS*2-1:0]   mux_select,
  output logic [NPORTS-1:0]     out_active
`ifdef ARB_TIMEOUT_EN
  ,
  input  logic                  timeout_clr,
  output logic [NPORTS-1:0]     timeout_err
`endif
);

  logic [NPORTS-1:0]   tgt [NPORTS];
  logic [NPORTS-1:0]   eligible;
  logic [NPORTS-1:0]   win;
  logic [NPORTS-1:0]   claimed;
  logic [1:0]          idx;
  logic                first_found;
  logic [1:0]          first_idx;

  logic [NPORTS-1:0]   grant_q, grant_d;
  logic [NPORTS*2-1:0] sel_q, sel_d;
  logic [NPORTS-1:0]   claimed_q, claimed_d;
  logic [NPORTS*2-1:0] mux_select_q, mux_select_d;
  logic [NPORTS-1:0]   out_active_q, out_active_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;

  for (genvar g = 0; g < NPORTS; g++) begin : g_tgt
    assign tgt[g] = req_target[4*g +: 4];
    // A target set touching any disabled output is never partially served.
    assign eligible[g] = req[g] & ~grant_q[g] & (tgt[g] != '0)
                       & ((tgt[g] & ~out_enable) == '0);
  end

  always_comb begin
    claimed     = '0;
    win         = '0;
    idx         = '0;
    first_found = 1'b0;
    first_idx   = '0;
    for (int k = 0; k < NPORTS; k++) begin
      idx = rr_ptr_q + k[1:0];
      if (eligible[idx] && ((tgt[idx] & claimed) == '0)) begin
        win[idx] = 1'b1;
        claimed  = claimed | tgt[idx];
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = idx;
        end
      end
    end
  end

  always_comb begin
    grant_d   = win;
    claimed_d = claimed;
    sel_d     = '0;
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (win[i] && tgt[i][o]) begin
          sel_d[2*o +: 2] = i[1:0];
        end
      end
    end
    rr_ptr_d = first_found ? (first_idx + 2'd1) : rr_ptr_q;
  end

  // Second stage: unallocated outputs read back as zero.
  always_comb begin
    out_active_d = claimed_q;
    mux_select_d = '0;
    for (int o = 0; o < NPORTS; o++) begin
      if (claimed_q[o]) begin
        mux_select_d[2*o +: 2] = sel_q[2*o +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q      <= '0;
      sel_q        <= '0;
      claimed_q    <= '0;
      mux_select_q <= '0;
      out_active_q <= '0;
      rr_ptr_q     <= '0;
    end else begin
      grant_q      <= grant_d;
      sel_q        <= sel_d;
      claimed_q    <= claimed_d;
      mux_select_q <= mux_select_d;
      out_active_q <= out_active_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign grant      = grant_q;
  assign mux_select = mux_select_q;
  assign out_active = out_active_q;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  logic [CW-1:0]     wait_cnt_q [NPORTS];
  logic [CW-1:0]     wait_cnt_d [NPORTS];
  logic [NPORTS-1:0] timeout_err_q, timeout_err_d;

  always_comb begin
    timeout_err_d = timeout_err_q;
    if (timeout_clr) begin
      timeout_err_d = '0;
    end
    for (int i = 0; i < NPORTS; i++) begin
      wait_cnt_d[i] = '0;
      if (req[i] && !win[i]) begin
        wait_cnt_d[i] = (wait_cnt_q[i] == LIMIT) ? wait_cnt_q[i] : wait_cnt_q[i] + 1'b1;
      end
      // A set in the same cycle as a clear takes priority.
      if (wait_cnt_d[i] == LIMIT) begin
        timeout_err_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err_q <= '0;
      for (int i = 0; i < NPORTS; i++) begin
        wait_cnt_q[i] <= '0;
      end
    end else begin
      timeout_err_q <= timeout_err_d;
      for (int i = 0; i < NPORTS; i++) begin
        wait_cnt_q[i] <= wait_cnt_d[i];
      end
    end
  end

  assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed bench for switch_arbiter: hand-computed grant / out_active / mux_select / rr_ptr vectors.
module tb_switch_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] req_target;
  logic [3:0]  out_enable;
  logic [3:0]  grant;
  logic [7:0]  mux_select;
  logic [3:0]  out_active;
`ifdef ARB_TIMEOUT_EN
  logic        timeout_clr;
  logic [3:0]  timeout_err;
`endif

  int n_checks;
  int n_fail;

  switch_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_target (req_target),
    .out_enable (out_enable),
    .grant      (grant),
    .mux_select (mux_select),
    .out_active (out_active)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout_clr(timeout_clr),
    .timeout_err(timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] g, input logic [3:0] oa,
                            input logic [7:0] ms);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".out_active"}, 32'(out_active), 32'(oa));
    check({tag, ".mux_select"}, 32'(mux_select), 32'(ms));
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    req        = '0;
    req_target = '0;
    out_enable = 4'b1111;
`ifdef ARB_TIMEOUT_EN
    timeout_clr = 1'b0;
`endif
    #12;
    check_outs("reset", 4'b0000, 4'b0000, 8'h00);
    check("reset.rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
`ifdef ARB_TIMEOUT_EN
    check("reset.timeout_err", 32'(timeout_err), 32'd0);
`endif
    #1 rst_n = 1'b1;

    // Single unicast: input 0 -> output 1.
    req = 4'b0001; req_target = 16'h0002;
    step();
    check_outs("t1.s1", 4'b0001, 4'b0000, 8'h00);
    check("t1.rr_ptr", 32'(dut.rr_ptr_q), 32'd1);
    req = '0;
    step();
    check_outs("t1.s2", 4'b0000, 4'b0010, 8'h00);

    // Two non-conflicting grants in one cycle.
    req = 4'b0011; req_target = 16'h0042;
    step();
    check_outs("t2.s1", 4'b0011, 4'b0000, 8'h00);
    check("t2.rr_ptr", 32'(dut.rr_ptr_q), 32'd2);
    req = '0;
    step();
    check_outs("t2.s2", 4'b0000, 4'b0110, 8'h10);

    // Broadcast from input 3 blocks input 1; rr starts at 2.
    req = 4'b1010; req_target = 16'hF010;
    step();
    check_outs("t4.s1", 4'b1000, 4'b0000, 8'h00);
    check("t4.rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
    req = '0;
    step();
    check_outs("t4.s2", 4'b0000, 4'b1111, 8'hFF);

    // Conflict on output 0: input 0 first, then input 2 while 0 is masked.
    req = 4'b0101; req_target = 16'h0101;
    step();
    check_outs("t3.s1", 4'b0001, 4'b0000, 8'h00);
    step();
    check_outs("t3.s2", 4'b0100, 4'b0001, 8'h00);
    check("t3.rr_ptr", 32'(dut.rr_ptr_q), 32'd3);
    req = '0;
    step();
    check_outs("t3.s3", 4'b0000, 4'b0001, 8'h02);

    // Output 0 disabled: request stalls until it is enabled.
    out_enable = 4'b1110; req = 4'b0001; req_target = 16'h0001;
    for (int c = 0; c < 63; c++) step();
    check_outs("t5.stall", 4'b0000, 4'b0000, 8'h00);
`ifdef ARB_TIMEOUT_EN
    check("t5.err_before", 32'(timeout_err), 32'd0);
`endif
    step();
    check("t5.stall_grant", 32'(grant), 32'd0);
`ifdef ARB_TIMEOUT_EN
    check("t5.err_set", 32'(timeout_err), 32'd1);
`endif
    out_enable = 4'b1111;
    step();
    check_outs("t5.enable", 4'b0001, 4'b0000, 8'h00);
    check("t5.rr_ptr", 32'(dut.rr_ptr_q), 32'd1);
    req = '0;
`ifdef ARB_TIMEOUT_EN
    check("t5.err_sticky", 32'(timeout_err), 32'd1);
    timeout_clr = 1'b1;
`endif
    step();
    check_outs("t5.s2", 4'b0000, 4'b0001, 8'h00);
`ifdef ARB_TIMEOUT_EN
    check("t5.err_clr", 32'(timeout_err), 32'd0);
    timeout_clr = 1'b0;
`endif

    // Held request: granted, masked for one cycle, granted again.
    req = 4'b0001; req_target = 16'h0002;
    step();
    check_outs("mask.s1", 4'b0001, 4'b0000, 8'h00);
    step();
    check_outs("mask.s2", 4'b0000, 4'b0010, 8'h00);
    step();
    check_outs("mask.s3", 4'b0001, 4'b0000, 8'h00);
    req = '0;
    step();
    check_outs("mask.s4", 4'b0000, 4'b0010, 8'h00);

    // Empty target mask is ignored.
    req = 4'b0010; req_target = 16'h0000;
    step();
    check_outs("tgt0.s1", 4'b0000, 4'b0000, 8'h00);
    req = '0;
    step();
    check_outs("tgt0.s2", 4'b0000, 4'b0000, 8'h00);

    // Self-targeting: input 2 -> output 2.
    req = 4'b0100; req_target = 16'h0400;
    step();
    check_outs("self.s1", 4'b0100, 4'b0000, 8'h00);
    check("self.rr_ptr", 32'(dut.rr_ptr_q), 32'd3);
    req = '0;
    step();
    check_outs("self.s2", 4'b0000, 4'b0100, 8'h20);

    // Asynchronous reset while outputs are active.
    req = 4'b0011; req_target = 16'h0042;
    step();
    check("rst.grant_pre", 32'(grant), 32'd3);
    req = '0;
    step();
    check_outs("rst.pre", 4'b0000, 4'b0110, 8'h10);
    check("rst.rr_pre", 32'(dut.rr_ptr_q), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_outs("rst.async", 4'b0000, 4'b0000, 8'h00);
    check("rst.rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
    #3 rst_n = 1'b1;
    step();
    check_outs("rst.after", 4'b0000, 4'b0000, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
